// File: rtl/prince_ctrl_pkg.sv
// Shared types and constants for the masked PRINCE round controllers.
package prince_ctrl_pkg;

   // Controller sequencing states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } ctrl_state_e;

   // Direction phase presented to the constant / linear-layer logic
   localparam logic [1:0] PH_FWD = 2'b00;
   localparam logic [1:0] PH_MID = 2'b01;
   localparam logic [1:0] PH_BWD = 2'b10;

   // Default geometry: 11 S-box layers, 2 register stages per layer
   localparam int DEF_NUM_ROUNDS = 11;
   localparam int DEF_STAGES     = 2;

   // Forward rounds come before the middle layer, backward rounds after it
   function automatic logic [1:0] round_phase_f(input int unsigned r,
                                                input int unsigned num_rounds);
      if (r < num_rounds / 2)
         return PH_FWD;
      else if (r == num_rounds / 2)
         return PH_MID;
      else
         return PH_BWD;
   endfunction

endpackage

// File: rtl/prince_round_ctrl_counter.sv
// Nested stage / round counter: stage counts modulo STAGES and carries into
// the round counter, which counts modulo NUM_ROUNDS. Shared with the
// decryption controller.
module stage_round_counter #(
   parameter int STAGES     = 2,
   parameter int NUM_ROUNDS = 11,
   parameter int S_W        = 1,
   parameter int R_W        = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr_i,
   input  logic           adv_i,
   output logic [S_W-1:0] stage_o,
   output logic [R_W-1:0] round_o,
   output logic           last_o
);

   logic [S_W-1:0] stage_q, stage_d;
   logic [R_W-1:0] round_q, round_d;
   logic           stage_last;
   logic           round_last;

   assign stage_last = (stage_q == S_W'(STAGES - 1));
   assign round_last = (round_q == R_W'(NUM_ROUNDS - 1));

   // Clear has priority; advance steps the stage and carries into the round
   always_comb begin
      stage_d = stage_q;
      round_d = round_q;
      if (clr_i) begin
         stage_d = '0;
         round_d = '0;
      end else if (adv_i) begin
         if (stage_last) begin
            stage_d = '0;
            round_d = round_last ? '0 : round_q + R_W'(1);
         end else begin
            stage_d = stage_q + S_W'(1);
         end
      end
   end

   // Counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q <= '0;
         round_q <= '0;
      end else begin
         stage_q <= stage_d;
         round_q <= round_d;
      end
   end

   assign stage_o = stage_q;
   assign round_o = round_q;
   assign last_o  = stage_last && round_last;

endmodule

// File: rtl/prince_round_ctrl.sv
// Sequencing controller for the round-based masked PRINCE datapath.
// One block per handshake: a LOAD cycle enabling stage 0 from the external
// input, then RUN cycles walking the stage enables round by round, then DONE
// holding the result until the consumer takes it. All outputs decode from
// the state register and counters only.
module prince_round_ctrl
   import prince_ctrl_pkg::*;
#(
   parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
   parameter int STAGES     = DEF_STAGES,
   parameter int RIDX_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              load_sel,
   output logic [STAGES-1:0] stage_en,
   output logic [RIDX_W-1:0] round_idx,
   output logic [1:0]        round_phase,
   output logic              rnd_en,
   output logic              busy
);

   // A single-stage layer still needs a one-bit counter
   localparam int S_W = (STAGES > 1) ? $clog2(STAGES) : 1;

   ctrl_state_e       state_q, state_d;
   logic              cnt_clr;
   logic              cnt_adv;
   logic              cnt_last;
   logic [S_W-1:0]    stage_cnt;
   logic [RIDX_W-1:0] round_cnt;
   logic              en_active;

   stage_round_counter #(
      .STAGES     (STAGES),
      .NUM_ROUNDS (NUM_ROUNDS),
      .S_W        (S_W),
      .R_W        (RIDX_W)
   ) u_counter (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (cnt_clr),
      .adv_i   (cnt_adv),
      .stage_o (stage_cnt),
      .round_o (round_cnt),
      .last_o  (cnt_last)
   );

   // State register; reset aborts any block in flight
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state and counter control. LOAD counts as the first enabled cycle
   // (stage 0 of round 0), so the counter advances in both LOAD and RUN.
   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      cnt_adv = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (in_valid)
               state_d = ST_LOAD;
         end
         ST_LOAD: begin
            cnt_adv = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            cnt_adv = 1'b1;
            if (cnt_last)
               state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign en_active = (state_q == ST_LOAD) || (state_q == ST_RUN);

   // One-hot stage enable: exactly the bit matching the stage counter
   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage_en
      assign stage_en[gi] = en_active && (stage_cnt == S_W'(gi));
   end

   // Output decode; round index and phase are parked at zero when idle
   always_comb begin
      in_ready    = (state_q == ST_IDLE);
      out_valid   = (state_q == ST_DONE);
      load_sel    = (state_q == ST_LOAD);
      rnd_en      = en_active;
      busy        = en_active;
      round_idx   = '0;
      round_phase = PH_FWD;
      if (en_active) begin
         round_idx   = round_cnt;
         round_phase = round_phase_f(32'(round_cnt), NUM_ROUNDS);
      end
   end

endmodule

// File: tb/tb_prince_round_ctrl.sv
// Directed bench: default geometry (11 rounds x 2 stages) and a small
// 3 rounds x 1 stage instance, with hand-derived expected sequences.
module tb_prince_round_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, out_ready;
   logic       in_ready, out_valid, load_sel, rnd_en, busy;
   logic [1:0] stage_en;
   logic [3:0] round_idx;
   logic [1:0] round_phase;

   logic       in_valid_b, out_ready_b;
   logic       in_ready_b, out_valid_b, load_sel_b, rnd_en_b, busy_b;
   logic [0:0] stage_en_b;
   logic [1:0] round_idx_b;
   logic [1:0] round_phase_b;

   int total = 0;
   int bad   = 0;

   prince_round_ctrl #(.NUM_ROUNDS(11), .STAGES(2), .RIDX_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .load_sel(load_sel),
      .stage_en(stage_en), .round_idx(round_idx), .round_phase(round_phase),
      .rnd_en(rnd_en), .busy(busy)
   );

   prince_round_ctrl #(.NUM_ROUNDS(3), .STAGES(1), .RIDX_W(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .load_sel(load_sel_b),
      .stage_en(stage_en_b), .round_idx(round_idx_b), .round_phase(round_phase_b),
      .rnd_en(rnd_en_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ph(input int r, input int nr);
      if (r < nr / 2) return 0;
      else if (r == nr / 2) return 1;
      else return 2;
   endfunction

   // Full default block: handshake, 22 enabled cycles, then DONE
   task automatic run_block0(input string name);
      int pulses;
      pulses = 0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 22; k++) begin
         chk({name, "_stage_en"}, 32'(stage_en), 32'(1 << (k % 2)));
         chk({name, "_round_idx"}, 32'(round_idx), 32'(k / 2));
         chk({name, "_phase"}, 32'(round_phase), 32'(ph(k / 2, 11)));
         chk({name, "_rnd_en"}, 32'(rnd_en), 32'(1));
         chk({name, "_load_sel"}, 32'(load_sel), (k == 0) ? 32'(1) : 32'(0));
         chk({name, "_busy"}, 32'(busy), 32'(1));
         chk({name, "_in_ready"}, 32'(in_ready), 32'(0));
         chk({name, "_out_valid_early"}, 32'(out_valid), 32'(0));
         if (stage_en != 2'b00) pulses++;
         tick();
      end
      chk({name, "_pulses"}, 32'(pulses), 32'(22));
      chk({name, "_out_valid"}, 32'(out_valid), 32'(1));
      chk({name, "_done_stage_en"}, 32'(stage_en), 32'(0));
      chk({name, "_done_rnd_en"}, 32'(rnd_en), 32'(0));
      chk({name, "_done_busy"}, 32'(busy), 32'(0));
      $display("txn %s: block complete, pulses=%0d", name, pulses);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_done, second_load, n, pulses_b;

      // Reset then idle
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_valid_b = 1'b0; out_ready_b = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_stage_en", 32'(stage_en), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_phase", 32'(round_phase), 32'(0));
      chk("rst_round_idx", 32'(round_idx), 32'(0));
      chk("rst_rnd_en", 32'(rnd_en), 32'(0));
      chk("rst_load_sel", 32'(load_sel), 32'(0));
      chk("rst_b_in_ready", 32'(in_ready_b), 32'(1));
      $display("txn reset: in_ready=%0b busy=%0b", in_ready, busy);

      // Single block with default geometry
      run_block0("single");

      // Backpressure in DONE
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", 32'(out_valid), 32'(1));
         chk("bp_stage_en", 32'(stage_en), 32'(0));
         chk("bp_rnd_en", 32'(rnd_en), 32'(0));
         chk("bp_in_ready", 32'(in_ready), 32'(0));
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_exit_in_ready", 32'(in_ready), 32'(1));
      chk("bp_exit_out_valid", 32'(out_valid), 32'(0));
      chk("bp_exit_busy", 32'(busy), 32'(0));
      $display("txn backpressure: released, in_ready=%0b", in_ready);

      // Back-to-back with in_valid and out_ready held high
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      first_done = -1; second_load = -1;
      for (int c = 0; c < 25; c++) begin
         chk("b2b_overlap", 32'(busy && out_valid), 32'(0));
         if (out_valid && first_done < 0) first_done = c;
         if (load_sel && c > 0 && second_load < 0) second_load = c;
         if (c == 23) chk("b2b_idle_in_ready", 32'(in_ready), 32'(1));
         tick();
      end
      chk("b2b_first_done", 32'(first_done), 32'(22));
      chk("b2b_second_load", 32'(second_load), 32'(24));
      in_valid = 1'b0;
      n = 0;
      while (!in_ready && n < 60) begin
         tick();
         n++;
      end
      chk("b2b_drain", 32'(in_ready), 32'(1));
      out_ready = 1'b0;
      $display("txn back_to_back: done_at=%0d reload_at=%0d", first_done, second_load);

      // Mid-run reset at round 4
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (8) tick();
      chk("mid_round_idx", 32'(round_idx), 32'(4));
      chk("mid_stage_en", 32'(stage_en), 32'(1));
      rst = 1'b1;
      tick();
      chk("mid_rst_stage_en", 32'(stage_en), 32'(0));
      chk("mid_rst_rnd_en", 32'(rnd_en), 32'(0));
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
      rst = 1'b0;
      tick();
      chk("mid_post_stage_en", 32'(stage_en), 32'(0));
      $display("txn mid_reset: aborted at round 4");
      run_block0("after_rst");
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("after_rst_in_ready", 32'(in_ready), 32'(1));

      // Small geometry: 3 rounds, 1 stage
      pulses_b = 0;
      in_valid_b = 1'b1;
      tick();
      in_valid_b = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("b_stage_en", 32'(stage_en_b), 32'(1));
         chk("b_round_idx", 32'(round_idx_b), 32'(k));
         chk("b_phase", 32'(round_phase_b), 32'(ph(k, 3)));
         chk("b_load_sel", 32'(load_sel_b), (k == 0) ? 32'(1) : 32'(0));
         chk("b_rnd_en", 32'(rnd_en_b), 32'(1));
         if (stage_en_b != 1'b0) pulses_b++;
         tick();
      end
      chk("b_pulses", 32'(pulses_b), 32'(3));
      chk("b_out_valid", 32'(out_valid_b), 32'(1));
      chk("b_done_stage_en", 32'(stage_en_b), 32'(0));
      out_ready_b = 1'b1;
      tick();
      out_ready_b = 1'b0;
      chk("b_exit_in_ready", 32'(in_ready_b), 32'(1));
      $display("txn small_geometry: pulses=%0d", pulses_b);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
